// File: rtl/spi_ram_phy_if.sv
// Request/response bus between the OBI SPI-RAM shim (master) and the SPI PHY (slave).
interface spi_ram_phy_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [2:0]  req_md_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_md_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_md_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/spi_ram_phy.sv
// SPI mode-0 PHY for 23LC-style serial SRAM: one cmd + address + 32-bit data word per CS-low window.
module spi_ram_phy #(
  parameter int unsigned ClkDiv   = 4,
  parameter int unsigned AddrBits = 24
) (
  input  logic           clk_i,
  input  logic           rst_i,
  spi_ram_phy_if.slave   bus,
  output logic           spi_sck_o,
  output logic           spi_cs_no,
  output logic           spi_mosi_o,
  input  logic           spi_miso_i
);

  localparam int unsigned FrameBits = 8 + AddrBits + 32;
  localparam int unsigned DataStart = 8 + AddrBits;
  localparam int unsigned HpW       = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int unsigned BitW      = $clog2(FrameBits);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, ERR} state_e;

  state_e                 state_q, state_d;
  logic                   live_q;
  logic [HpW-1:0]         hp_q;
  logic [BitW-1:0]        bit_q;
  logic                   sck_q;
  logic                   rd_q;
  logic [FrameBits-1:0]   frame_q;
  logic [31:0]            rx_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic [31:0]            rsp_rdata_q;

  logic hp_last, bit_last, legal_md, accept;
  logic addr_unused;

  // Words travel little-endian by byte, each byte MSB-first.
  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  assign hp_last     = (hp_q == HpW'(ClkDiv - 1));
  assign bit_last    = (bit_q == BitW'(FrameBits - 1));
  assign legal_md    = (bus.req_md_i[2:1] == 2'b00);
  assign accept      = (state_q == IDLE) && live_q && bus.req_valid_i;
  assign addr_unused = ^bus.req_addr_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = legal_md ? SHIFT : ERR;
      SHIFT: if (hp_last && sck_q && bit_last) state_d = GAP;
      GAP:   if (hp_last) state_d = IDLE;
      ERR:   state_d = IDLE;
    endcase
  end

  // live_q keeps ready low during the first cycle after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live_q      <= 1'b0;
      hp_q        <= '0;
      bit_q       <= '0;
      sck_q       <= 1'b0;
      rd_q        <= 1'b0;
      frame_q     <= '0;
      rx_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      live_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          hp_q  <= '0;
          bit_q <= '0;
          sck_q <= 1'b0;
          if (accept) begin
            if (legal_md) begin
              rd_q    <= ~bus.req_md_i[0];
              frame_q <= {(bus.req_md_i[0] ? 8'h02 : 8'h03),
                          bus.req_addr_i[AddrBits-1:0],
                          (bus.req_md_i[0] ? bswap(bus.req_wdata_i) : 32'h0)};
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (hp_last) begin
            hp_q  <= '0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              if (rd_q && (bit_q >= BitW'(DataStart))) rx_q <= {rx_q[30:0], spi_miso_i};
            end else if (bit_last) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= rd_q ? bswap(rx_q) : '0;
            end else begin
              bit_q   <= bit_q + BitW'(1);
              frame_q <= {frame_q[FrameBits-2:0], 1'b0};
            end
          end else begin
            hp_q <= hp_q + HpW'(1);
          end
        end
        GAP:  hp_q <= hp_q + HpW'(1);
        ERR:  ;
      endcase
    end
  end

  assign bus.req_ready_o = live_q && (state_q == IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign spi_cs_no       = (state_q != SHIFT);
  assign spi_sck_o       = sck_q;
  assign spi_mosi_o      = (state_q == SHIFT) && frame_q[FrameBits-1];

endmodule

// File: doc/spi_ram_phy.md
Name: spi_ram_phy

Overview:
- Serializes word-level requests from the OBI SPI-RAM shim onto a 4-wire SPI bus, using SPI mode 0 and a 23LC-style serial SRAM protocol.
- Sits directly downstream of the shim. It consumes the shim's address, write data and mode, and returns read data plus a one-cycle response pulse.
- Each transaction is one 8-bit command, a 24-bit address and 32 data bits, all within a single CS-low window.

Parameters:
ClkDiv, 4, SCK half-period in clk_i cycles; legal values are 1 or greater.
AddrBits, 24, number of address bits shifted out; must be a multiple of 8.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  1  request valid from the shim
req_ready_o  out  1  request accepted in the cycle where valid and ready are both high
req_addr_i  in  32  byte address relative to RAM base; only [AddrBits-1:0] is used
req_wdata_i  in  32  write data
req_md_i  in  3  mode: 3'b000 = read word, 3'b001 = write word, all other values reserved
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  32  read data, held until the next response
rsp_err_o  out  1  error flag, qualified by rsp_valid_o
spi_sck_o  out  1  serial clock
spi_cs_no  out  1  chip select, active low
spi_mosi_o  out  1  serial data out
spi_miso_i  in  1  serial data in

Behaviour:
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, spi_sck_o=0, spi_cs_no=1, spi_mosi_o=0. Reset acts asynchronously on all state.
- FSM states: IDLE, SHIFT, GAP, ERR.
- req_ready_o is 1 only in IDLE.
- Accept cycle T with a legal mode: latch the inputs, then move to SHIFT.
  - Transmit frame is 64 bits: cmd (0x03 read / 0x02 write), then address MSB-first, then data.
- Accept cycle T with a reserved mode: move to ERR.
  - At T+1: rsp_valid_o=1, rsp_err_o=1.
  - No SPI activity; rsp_rdata_o is unchanged.
  - Then return to IDLE.
- Data byte order: little-endian bytes, each byte MSB-first.
  - Write: wdata[7:0] is sent first, wdata[31:24] last.
  - Read: the first received byte lands in rdata[7:0].
- SHIFT timing (B = 8+AddrBits+32 bits, N = 2*ClkDiv*B cycles):
  - spi_cs_no is low for exactly N cycles, T+1 through T+N.
  - Bit k's half-period boundaries are relative to T+1.
  - spi_mosi_o presents bit k from cycle T+1+2*ClkDiv*k.
  - spi_sck_o is high during [T+1+2*ClkDiv*k+ClkDiv, T+2*ClkDiv*(k+1)] and low otherwise.
  - spi_miso_i is sampled on the clk_i edge where spi_sck_o goes 0→1. This sampling happens only during data bits of a read.
  - A half-period counter is compared to ClkDiv-1; a bit counter runs 0..B-1.
- During write data bits, MISO is ignored. During read data bits, spi_mosi_o=0.
- End of transaction, at cycle T+N+1:
  - spi_cs_no=1, spi_sck_o=0, spi_mosi_o=0.
  - rsp_valid_o=1, rsp_err_o=0.
  - rsp_rdata_o is updated on a read. On a write it is set to 0.
  - Then move to GAP.
- GAP: spi_cs_no is held high for ClkDiv cycles with req_ready_o=0, then return to IDLE.
  - Back-to-back requests therefore have at least ClkDiv+1 cycles of CS-high between windows.
- Inputs are latched at accept. Changes to req_* after accept have no effect.
- req_valid_i may be held high while not ready. The request is accepted on the first cycle ready is high; no request is dropped or duplicated.
- Reset mid-SHIFT:
  - CS deasserts immediately and SCK returns low.
  - No response is issued.
  - After release, ready asserts on the first clk_i edge (IDLE).
- Only one transaction is in flight at a time; there is no buffering.

Test Plan:
1. ClkDiv=2, write md=001, addr=0x00000104, wdata=0xDEADBEEF.
   - MOSI byte stream must be 02 00 01 04 EF BE AD DE.
   - spi_cs_no is low for 256 cycles.
   - rsp_valid_o pulses at T+257 with err=0.
2. ClkDiv=2, read addr=0x000010, SRAM model drives MISO bytes 11 22 33 44.
   - Command/address stream must be 03 00 00 10.
   - rsp_rdata_o=0x44332211, err=0.
3. Reserved md=3'b111.
   - rsp_valid_o=1 and err=1 at T+1.
   - spi_cs_no never falls; rdata is unchanged.
4. req_valid_i held high across two requests.
   - Exactly two accepts and two responses.
   - CS-high gap of at least ClkDiv+1 cycles between windows.
   - Second request's inputs are changed during the first and are honoured.
5. ClkDiv=1 corner: write then read the same address via the model.
   - SCK toggles every cycle during SHIFT.
   - Read data equals the written data.
6. Assert rst_i midway through the data phase of a write.
   - spi_cs_no=1 and spi_sck_o=0 immediately, with no rsp_valid_o.
   - req_ready_o=1 one cycle after release.
